// File: rtl/fifo_write_packer.sv
// Packs PAR_WRITE consecutive BITS-wide samples into one word and writes it to a parallel-write FIFO.
// Optional PACKER_FLUSH_EN adds a flush input that zero-pads and pushes a partial word.
module fifo_write_packer #(
    parameter int PAR_WRITE = 1,
    parameter int BITS      = 16,
    localparam int LW       = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [BITS-1:0]           in_data,
    output logic                      in_ready,
`ifdef PACKER_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic                      fifo_full,
    output logic                      fifo_wen,
    output logic                      fifo_cnt_w,
    output logic [BITS*PAR_WRITE-1:0] fifo_din,
    output logic [LW-1:0]             lane_cnt
);

    typedef enum logic {COLLECT, PUSH} state_t;

    localparam logic [LW-1:0] LAST_LANE = LW'(PAR_WRITE - 1);

    state_t                    state, state_next;
    logic [LW-1:0]             lane_next;
    logic [BITS*PAR_WRITE-1:0] word, word_next;
    logic                      accept;
`ifdef PACKER_FLUSH_EN
    logic [LW:0]               fill;
`endif

    // Reset gates both the handshake and the write so nothing leaks out during rst.
    assign in_ready   = !rst && ((state == COLLECT) || !fifo_full);
    assign fifo_wen   = !rst && (state == PUSH) && !fifo_full;
    assign fifo_cnt_w = fifo_wen;
    assign fifo_din   = word;
    assign accept     = in_valid && in_ready;

    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        lane_next  = lane_cnt;
        word_next  = word;
`ifdef PACKER_FLUSH_EN
        fill       = '0;
`endif
        case (state)
            COLLECT: begin
                if (accept) begin
                    word_next[int'(lane_cnt)*BITS +: BITS] = in_data;
                    if (lane_cnt == LAST_LANE) begin
                        lane_next  = '0;
                        state_next = PUSH;
                    end else begin
                        lane_next = lane_cnt + LW'(1);
                    end
                end
`ifdef PACKER_FLUSH_EN
                // Flush sees the fill count including a sample accepted this same cycle.
                fill = {1'b0, lane_cnt} + (LW+1)'(accept);
                if (flush && (fill != '0)) begin
                    for (int k = 0; k < PAR_WRITE; k++) begin
                        if (k >= int'(fill)) word_next[k*BITS +: BITS] = '0;
                    end
                    lane_next  = '0;
                    state_next = PUSH;
                end
`endif
            end
            PUSH: begin
                if (!fifo_full) begin
                    // The FIFO captures the current word at this edge; lane 0 of the next word is overwritten alongside.
                    if (accept) begin
                        word_next[BITS-1:0] = in_data;
                        if (PAR_WRITE == 1) begin
                            state_next = PUSH;
                        end else begin
                            lane_next  = LW'(1);
                            state_next = COLLECT;
                        end
                    end else begin
                        lane_next  = '0;
                        state_next = COLLECT;
                    end
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the word register is cleared on reset so fifo_din starts at a known zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= COLLECT;
            lane_cnt <= '0;
            word     <= '0;
        end else begin
            state    <= state_next;
            lane_cnt <= lane_next;
            word     <= word_next;
        end
    end

endmodule

// File: tb/tb_fifo_write_packer.sv
// Scoreboard bench for fifo_write_packer: PAR_WRITE=4 and PAR_WRITE=1 instances, BITS=16.
// Expected words are queued by the stimulus; a negedge monitor pops them on every fifo_wen.
module tb_fifo_write_packer;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, fifo_full, fifo_wen, fifo_cnt_w;
    logic [15:0] in_data;
    logic [63:0] fifo_din;
    logic [1:0]  lane_cnt;
`ifdef PACKER_FLUSH_EN
    logic        flush;
`endif

    logic        valid1, ready1, full1, wen1, cnt_w1;
    logic [15:0] data1, din1;
    logic        lane1;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q4[$];
    logic [63:0] q1[$];

    fifo_write_packer #(.PAR_WRITE(4), .BITS(16)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
`ifdef PACKER_FLUSH_EN
        .flush(flush),
`endif
        .fifo_full(fifo_full), .fifo_wen(fifo_wen), .fifo_cnt_w(fifo_cnt_w),
        .fifo_din(fifo_din), .lane_cnt(lane_cnt)
    );

    fifo_write_packer #(.PAR_WRITE(1), .BITS(16)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(valid1), .in_data(data1), .in_ready(ready1),
`ifdef PACKER_FLUSH_EN
        .flush(1'b0),
`endif
        .fifo_full(full1), .fifo_wen(wen1), .fifo_cnt_w(cnt_w1),
        .fifo_din(din1), .lane_cnt(lane1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitors: every write must match the next queued word and must never occur while full.
    always @(negedge clk) begin
        if (fifo_wen) begin
            check("p4_no_write_when_full", 64'(fifo_full), 64'd0);
            check("p4_cnt_w", 64'(fifo_cnt_w), 64'(fifo_wen));
            if (q4.size() == 0) check("p4_unexpected_write", fifo_din, 64'hDEAD);
            else                check("p4_din", fifo_din, q4.pop_front());
        end
        if (wen1) begin
            check("p1_cnt_w", 64'(cnt_w1), 64'(wen1));
            if (q1.size() == 0) check("p1_unexpected_write", 64'(din1), 64'hDEAD);
            else                check("p1_din", 64'(din1), q1.pop_front());
        end
    end

    // One PAR_WRITE=4 cycle: drive inputs, check status mid-cycle, advance past the edge.
    task automatic cyc(input logic v, input logic [15:0] d, input logic full,
                       input logic exp_ready, input logic exp_wen, input logic [1:0] exp_lane,
                       input string name);
        in_valid  = v;
        in_data   = d;
        fifo_full = full;
        @(negedge clk);
        check({name, "_ready"}, 64'(in_ready), 64'(exp_ready));
        check({name, "_wen"},   64'(fifo_wen), 64'(exp_wen));
        check({name, "_lane"},  64'(lane_cnt), 64'(exp_lane));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; fifo_full = 1'b0;
        valid1 = 1'b0; data1 = '0; full1 = 1'b0;
`ifdef PACKER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_wen",   64'(fifo_wen), 64'd0);
        check("rst_lane",  64'(lane_cnt), 64'd0);
        check("rst_din",   fifo_din,      64'd0);
        check("rst_ready1", 64'(ready1),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Continuous stream of 8 samples: writes one cycle after the 4th and 8th accepts.
        q4.push_back(64'h0004_0003_0002_0001);
        q4.push_back(64'h0008_0007_0006_0005);
        cyc(1, 16'h0001, 0, 1, 0, 0, "s1");
        cyc(1, 16'h0002, 0, 1, 0, 1, "s2");
        cyc(1, 16'h0003, 0, 1, 0, 2, "s3");
        cyc(1, 16'h0004, 0, 1, 0, 3, "s4");
        cyc(1, 16'h0005, 0, 1, 1, 0, "s5");
        cyc(1, 16'h0006, 0, 1, 0, 1, "s6");
        cyc(1, 16'h0007, 0, 1, 0, 2, "s7");
        cyc(1, 16'h0008, 0, 1, 0, 3, "s8");
        cyc(0, 16'h0000, 0, 1, 1, 0, "s_tail");
        cyc(0, 16'h0000, 0, 1, 0, 0, "s_idle");

        // Complete word, FIFO full for 3 cycles, then release with a same-cycle accept of 0x0009.
        cyc(1, 16'h0001, 0, 1, 0, 0, "f1");
        cyc(1, 16'h0002, 0, 1, 0, 1, "f2");
        cyc(1, 16'h0003, 0, 1, 0, 2, "f3");
        cyc(1, 16'h0004, 0, 1, 0, 3, "f4");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'h0009, 1, 0, 0, 0, "stall");
            check("stall_din_held", fifo_din, 64'h0004_0003_0002_0001);
        end
        q4.push_back(64'h0004_0003_0002_0001);
        cyc(1, 16'h0009, 0, 1, 1, 0, "release");
        cyc(1, 16'h000A, 0, 1, 0, 1, "o2");
        cyc(1, 16'h000B, 0, 1, 0, 2, "o3");
        cyc(1, 16'h000C, 0, 1, 0, 3, "o4");
        q4.push_back(64'h000C_000B_000A_0009);
        cyc(0, 16'h0000, 0, 1, 1, 0, "overlap_word");

`ifdef PACKER_FLUSH_EN
        // Flush with nothing filled is ignored; flush after two samples pads lanes 2-3 with zero.
        flush = 1'b1;
        cyc(0, 16'h0000, 0, 1, 0, 0, "flush_empty");
        flush = 1'b0;
        cyc(0, 16'h0000, 0, 1, 0, 0, "flush_empty_after");
        cyc(1, 16'h0011, 0, 1, 0, 0, "fl1");
        cyc(1, 16'h0022, 0, 1, 0, 1, "fl2");
        flush = 1'b1;
        cyc(0, 16'h0000, 0, 1, 0, 2, "flush_req");
        flush = 1'b0;
        q4.push_back(64'h0000_0000_0022_0011);
        cyc(0, 16'h0000, 0, 1, 1, 0, "flush_write");
        cyc(0, 16'h0000, 0, 1, 0, 0, "flush_done");
`endif

        // Reset mid-word discards the partial word.
        cyc(1, 16'hAAAA, 0, 1, 0, 0, "pw1");
        cyc(1, 16'hBBBB, 0, 1, 0, 1, "pw2");
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("midrst_ready", 64'(in_ready), 64'd0);
        check("midrst_wen",   64'(fifo_wen), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        q4.push_back(64'h0104_0103_0102_0101);
        cyc(1, 16'h0101, 0, 1, 0, 0, "n1");
        cyc(1, 16'h0102, 0, 1, 0, 1, "n2");
        cyc(1, 16'h0103, 0, 1, 0, 2, "n3");
        cyc(1, 16'h0104, 0, 1, 0, 3, "n4");
        cyc(0, 16'h0000, 0, 1, 1, 0, "n_write");

        // Reset while in PUSH suppresses the write.
        cyc(1, 16'h0021, 0, 1, 0, 0, "r1");
        cyc(1, 16'h0022, 0, 1, 0, 1, "r2");
        cyc(1, 16'h0023, 0, 1, 0, 2, "r3");
        cyc(1, 16'h0024, 0, 1, 0, 3, "r4");
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("pushrst_wen",   64'(fifo_wen), 64'd0);
        check("pushrst_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(0, 16'h0000, 0, 1, 0, 0, "pushrst_after");
        check("pushrst_din_cleared", fifo_din, 64'd0);

        // PAR_WRITE=1: one write per cycle carrying the previous cycle's sample.
        for (int i = 0; i < 6; i++) begin
            valid1 = 1'b1;
            data1  = 16'h1000 + 16'(i);
            @(negedge clk);
            check("p1_ready", 64'(ready1), 64'd1);
            check("p1_wen",   64'(wen1),   (i == 0) ? 64'd0 : 64'd1);
            q1.push_back(64'h1000 + 64'(i));
            @(posedge clk); #1;
        end
        valid1 = 1'b0;
        @(negedge clk);
        check("p1_tail_wen", 64'(wen1), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("p1_idle_wen", 64'(wen1), 64'd0);
        @(posedge clk); #1;

        check("q4_drained", 64'(q4.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/fifo_write_packer.md
Name: fifo_write_packer

Overview:
- Upstream feeder for the parallel-write circular-buffer FIFO.
- Accepts one BITS-wide sample per cycle over a valid/ready handshake and packs PAR_WRITE consecutive samples into one wide word.
- Issues a single write (wen + cnt_w) to the FIFO datapath/controller when the word is complete and the FIFO is not full.
- Applies back-pressure to the producer while a packed word is stalled on a full FIFO.

Parameters:
- PAR_WRITE, 1, samples per FIFO write; must match the FIFO's PAR_WRITE; legal values are >= 1.
- BITS, 16, width of one sample; must match the FIFO's BITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  producer has a sample on in_data.
- in_data  input  BITS  sample value.
- in_ready  output  1  packer can take a sample; transfer occurs when in_valid & in_ready are both high at the clock edge.
- fifo_full  input  1  FIFO full flag.
- fifo_wen  output  1  FIFO write enable.
- fifo_cnt_w  output  1  advance the FIFO write pointer by PAR_WRITE; always equal to fifo_wen.
- fifo_din  output  BITS*PAR_WRITE  packed word; lane k occupies bits [BITS*(k+1)-1 : BITS*k].
- lane_cnt  output  max(1,$clog2(PAR_WRITE))  index of the next lane to fill (status only).

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset values (applied at the clk edge with rst=1):
  - state=COLLECT, lane_cnt=0, word register=0.
  - fifo_wen=0, fifo_cnt_w=0.
  - in_ready is forced to 0 while rst=1.
- States: COLLECT, PUSH.
- COLLECT:
  - in_ready=1; fifo_wen=0.
  - On accept, lane[lane_cnt] <= in_data.
  - If lane_cnt==PAR_WRITE-1: lane_cnt <= 0 and go to PUSH. Otherwise lane_cnt <= lane_cnt+1.
- PUSH:
  - fifo_wen = fifo_cnt_w = !fifo_full (combinational).
  - in_ready = !fifo_full.
  - If fifo_full=1: hold the word and lane_cnt; stay in PUSH. No write, no accept.
  - If fifo_full=0: the word is written this cycle.
    - With a simultaneous accept: the sample goes to lane 0 of the next word. Then, if PAR_WRITE==1, stay in PUSH; otherwise set lane_cnt=1 and go to COLLECT.
    - Without an accept: go to COLLECT with lane_cnt=0.
- fifo_din:
  - Driven directly from the word register.
  - Stable for the whole time the block is in PUSH.
  - An overwrite of lane 0 on the write cycle takes effect after the edge, so the FIFO captures the completed word.
- Latency:
  - The word is presented the cycle after its last sample is accepted (no stall).
  - Sustained throughput is one sample per cycle when the FIFO is never full, including PAR_WRITE=1.
- Write rules:
  - The block never asserts fifo_wen while fifo_full=1.
  - Exactly one write per PAR_WRITE accepted samples.
  - Sample order is preserved: the earliest sample goes in lane 0.
- in_valid=0 in any state: no state change except the PUSH write described above.
- rst mid-word: the partial word is discarded and the block returns to the reset values.
- rst in PUSH: no write occurs in that cycle, because fifo_wen is gated by rst.

Optional Feature:
- Macro: PACKER_FLUSH_EN.
- Enabled: adds input port flush (1 bit).
  - In COLLECT, flush=1 evaluates after any same-cycle accept.
  - If the resulting fill count is > 0, all unfilled lanes are zeroed, lane_cnt goes to 0 and the block goes to PUSH; the word is written normally.
  - flush with zero filled lanes is ignored.
  - flush in PUSH is ignored.
- Disabled: no flush port; partial words wait indefinitely for more samples.

Test Plan (PAR_WRITE=4, BITS=16 unless stated):
- Reset then stream 0x0001..0x0008 with in_valid held high and fifo_full=0:
  - fifo_wen pulses twice, one cycle after the 4th and 8th accepts.
  - fifo_din = 0x0004_0003_0002_0001, then 0x0008_0007_0006_0005.
  - fifo_cnt_w equals fifo_wen.
- Complete word 0x0004_0003_0002_0001 with fifo_full=1 for 3 cycles:
  - in_ready=0 and fifo_wen=0 for those 3 cycles, and fifo_din is held.
  - On the cycle fifo_full drops, exactly one write occurs.
- PAR_WRITE=1, continuous valid, fifo_full=0: one write per cycle, fifo_din equal to the sample accepted the previous cycle, in_ready never low.
- Accept 2 samples (0xAAAA, 0xBBBB), assert rst for 1 cycle, then stream 4 new samples: the first write is the 4 new samples only; lane_cnt=0 after reset.
- Write cycle with simultaneous accept of 0x0009:
  - The next word's lane 0 = 0x0009.
  - lane_cnt=1 after the edge.
  - The written word is unaffected.
- PACKER_FLUSH_EN: accept 0x0011, 0x0022, then flush=1 → one write with fifo_din = 0x0000_0000_0022_0011; flush with lane_cnt=0 produces no write.
